// File: rtl/dmem_pkg.sv
// Shared constants and FSM encoding for the data-memory responder.
package dmem_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int CNT_W      = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_RESP = ST_RESP
  } state_t;
endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, asynchronous read.
module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 200
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
  end

  assign rdata = r_mem[addr];
endmodule

// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder with programmable wait states.
// Define DATA_MEM_STATS_EN to add saturating load/store response counters.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = 200,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
`ifdef DATA_MEM_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);
  localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  logic                w_accept, w_hs, w_enter_resp;
  logic                w_op_write, w_in_range, w_we;
  logic [ADDR_W-1:0]   w_op_addr;
  logic [DATA_W-1:0]   w_op_wdata, w_mem_rdata;

  assign req_ready = reset & (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  assign w_accept = req_valid & req_ready;
  assign w_hs     = rsp_valid & rsp_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (WAIT_CYCLES == 0) begin
          w_state_nxt  = S_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt  = S_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_RESP: if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // With zero wait states the commit happens on the accept edge, before the
  // holding registers are loaded, so the request inputs feed the commit directly.
  assign w_op_write = (r_state == S_IDLE) ? req_write : r_write;
  assign w_op_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_op_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_in_range = ({1'b0, w_op_addr} < DEPTH_L);
  assign w_we       = w_enter_resp & w_op_write & w_in_range;

  dmem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (w_we),
    .addr  (w_op_addr),
    .wdata (w_op_wdata),
    .rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_enter_resp) begin
        r_rdata <= !w_in_range ? '0 : (w_op_write ? w_op_wdata : w_mem_rdata);
        r_err   <= !w_in_range;
      end else if (w_hs) begin
        r_err   <= 1'b0;
      end
    end
  end

`ifdef DATA_MEM_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (w_hs) begin
      if (!r_write && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if ( r_write && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end
`endif
endmodule
